// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: latches watchdog/software/I-O interrupt causes, arbitrates them by fixed
// priority and runs the request/ack/return handshake with the control unit.
`default_nettype none

module interrupt_sequencer #(
    parameter int ACK_TIMEOUT = 15,
    parameter int TIMER_WIDTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wd_timeout,
    input  logic       io_irq,
    input  logic       swi,
    input  logic       mask_we,
    input  logic [2:0] mask_wdata,
    input  logic       irq_ack,
    input  logic       irq_return,
    output logic       irq_req,
    output logic [1:0] irq_cause,
    output logic       is_special_mode,
    output logic [2:0] pending,
    output logic [2:0] mask,
    output logic       ack_error
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_VAL = TIMER_WIDTH'(ACK_TIMEOUT);

    state_t                 state_q;
    logic [2:0]             pending_q, pending_d;
    logic [2:0]             mask_q, mask_d;
    logic [2:0]             eligible;
    logic [2:0]             clr_vec;
    logic [1:0]             win_cause;
    logic [1:0]             irq_cause_q;
    logic                   irq_req_q;
    logic                   special_q;
    logic                   ack_error_q, ack_error_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   ack_taken;

    always_comb begin
        ack_taken = (state_q == ST_REQUEST) && irq_ack;
        eligible  = pending_q & ~mask_q;

        win_cause = 2'd0;
        if (eligible[0])      win_cause = 2'd1;
        else if (eligible[1]) win_cause = 2'd2;
        else if (eligible[2]) win_cause = 2'd3;

        clr_vec = 3'b000;
        if (ack_taken) begin
            case (irq_cause_q)
                2'd1:    clr_vec = 3'b001;
                2'd2:    clr_vec = 3'b010;
                2'd3:    clr_vec = 3'b100;
                default: clr_vec = 3'b000;
            endcase
        end

        // A source active in the ack cycle re-latches, so set wins over clear.
        pending_d = (pending_q & ~clr_vec) | {io_irq, swi, wd_timeout};

        // Watchdog stays non-maskable.
        mask_d = mask_we ? {mask_wdata[2:1], 1'b0} : mask_q;

        timer_d = '0;
        if ((state_q == ST_REQUEST) && !irq_ack) begin
            timer_d = (timer_q == TIMEOUT_VAL) ? timer_q : timer_q + 1'b1;
        end
        ack_error_d = ack_error_q | (timer_d == TIMEOUT_VAL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= 3'b000;
            mask_q      <= 3'b000;
            irq_req_q   <= 1'b0;
            irq_cause_q <= 2'd0;
            special_q   <= 1'b0;
            ack_error_q <= 1'b0;
            timer_q     <= '0;
        end else begin
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            timer_q     <= timer_d;
            ack_error_q <= ack_error_d;
            case (state_q)
                ST_IDLE: begin
                    irq_cause_q <= win_cause;
                    if (win_cause != 2'd0) begin
                        irq_req_q <= 1'b1;
                        state_q   <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (irq_ack) begin
                        irq_req_q <= 1'b0;
                        special_q <= 1'b1;
                        state_q   <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (irq_return) begin
                        special_q   <= 1'b0;
                        irq_cause_q <= 2'd0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    irq_req_q   <= 1'b0;
                    irq_cause_q <= 2'd0;
                    special_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req         = irq_req_q;
    assign irq_cause       = irq_cause_q;
    assign is_special_mode = special_q;
    assign pending         = pending_q;
    assign mask            = mask_q;
    assign ack_error       = ack_error_q;

endmodule

`default_nettype wire
